// File: rtl/sm4_sbox_arb.sv
// sm4_sbox_arb
//   Shares one 32-bit SM4 S-box datapath between the round-function datapath
//   (requester 0) and the key-expansion engine (requester 1). Round-robin
//   arbitration with burst lock. A tag pipeline follows each lookup through
//   the S-box, and each result goes back to the requester that issued it.
//
// Ports
//   CLK_i, RSTn_i          clock, synchronous active-low reset
//   EN_i                   global enable for new grants
//   reqN_valid/data/lock   requester N lookup word and burst-lock request
//   reqN_ready_o           requester N word accepted this cycle (combinational)
//   rspN_valid/data_o      requester N result, single-cycle pulse
//   sbox_x_o / sbox_y_i    registered word into / result from the shared S-box
//   busy_o                 at least one lookup in flight
module sm4_sbox_arb #(
  parameter int SBOX_LAT = 1,
  parameter int DW       = 32
) (
  input  logic          CLK_i,
  input  logic          RSTn_i,
  input  logic          EN_i,
  input  logic          req0_valid_i,
  input  logic [DW-1:0] req0_data_i,
  input  logic          req0_lock_i,
  output logic          req0_ready_o,
  output logic          rsp0_valid_o,
  output logic [DW-1:0] rsp0_data_o,
  input  logic          req1_valid_i,
  input  logic [DW-1:0] req1_data_i,
  input  logic          req1_lock_i,
  output logic          req1_ready_o,
  output logic          rsp1_valid_o,
  output logic [DW-1:0] rsp1_data_o,
  output logic [DW-1:0] sbox_x_o,
  input  logic [DW-1:0] sbox_y_i,
  output logic          busy_o
);

  logic                last_grant_q, last_grant_d;
  logic [DW-1:0]       sbox_x_q, sbox_x_d;
  logic [SBOX_LAT:0]   tag_vld_q, tag_vld_d;
  logic [SBOX_LAT:0]   tag_id_q, tag_id_d;
  logic                rsp0_valid_q, rsp0_valid_d;
  logic                rsp1_valid_q, rsp1_valid_d;
  logic [DW-1:0]       rsp0_data_q, rsp0_data_d;
  logic [DW-1:0]       rsp1_data_q, rsp1_data_d;

  logic gnt0, gnt1, xfer, ret, ret_id;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    // Readies are held low while reset is asserted so nothing is accepted
    // in a cycle whose edge is going to clear the pipeline anyway.
    if (RSTn_i && EN_i) begin
      if (req0_valid_i && !req1_valid_i) begin
        gnt0 = 1'b1;
      end else if (!req0_valid_i && req1_valid_i) begin
        gnt1 = 1'b1;
      end else if (req0_valid_i && req1_valid_i) begin
        // Lock only counts for whoever holds last_grant; otherwise rotate.
        if (last_grant_q) begin
          if (req1_lock_i) gnt1 = 1'b1;
          else             gnt0 = 1'b1;
        end else begin
          if (req0_lock_i) gnt0 = 1'b1;
          else             gnt1 = 1'b1;
        end
      end
    end
    xfer = gnt0 | gnt1;

    last_grant_d = xfer ? gnt1 : last_grant_q;
    sbox_x_d     = gnt1 ? req1_data_i : (gnt0 ? req0_data_i : sbox_x_q);

    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = xfer;
    tag_id_d[0]  = gnt1;
    for (int i = 1; i <= SBOX_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end

    // Last tag stage lines up with sbox_y_i carrying that word's result.
    ret    = tag_vld_q[SBOX_LAT];
    ret_id = tag_id_q[SBOX_LAT];
    rsp0_valid_d = ret & ~ret_id;
    rsp1_valid_d = ret & ret_id;
    rsp0_data_d  = (ret && !ret_id) ? sbox_y_i : rsp0_data_q;
    rsp1_data_d  = (ret && ret_id)  ? sbox_y_i : rsp1_data_q;
  end

  always_ff @(posedge CLK_i) begin
    if (!RSTn_i) begin
      last_grant_q <= 1'b1;
      sbox_x_q     <= '0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      sbox_x_q     <= sbox_x_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;
  assign sbox_x_o     = sbox_x_q;
  assign rsp0_valid_o = rsp0_valid_q;
  assign rsp1_valid_o = rsp1_valid_q;
  assign rsp0_data_o  = rsp0_data_q;
  assign rsp1_data_o  = rsp1_data_q;
  assign busy_o       = (|tag_vld_q) | rsp0_valid_q | rsp1_valid_q;

endmodule

// File: tb/tb_sm4_sbox_arb.sv
// tb_sm4_sbox_arb
//   Directed bench for sm4_sbox_arb. Instance a uses SBOX_LAT=1 and instance b
//   uses SBOX_LAT=3, each with a pipelined S-box stand-in. Inputs are driven
//   1 time unit after the rising edge and outputs are sampled on the falling edge.
module tb_sm4_sbox_arb;

  // First 16 entries of the SM4 S-box; stimulus bytes stay within 0x00..0x0F.
  localparam logic [7:0] SB [16] = '{
    8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7,
    8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05};

  function automatic logic [31:0] sub32(input logic [31:0] x);
    logic [3:0] b3, b2, b1, b0;
    b3 = x[27:24]; b2 = x[19:16]; b1 = x[11:8]; b0 = x[3:0];
    return {SB[b3], SB[b2], SB[b1], SB[b0]};
  endfunction

  function automatic logic [31:0] mk(input int n);
    logic [7:0] a, b, c, d;
    a = 8'((n)      % 16);
    b = 8'((n + 5)  % 16);
    c = 8'((n + 9)  % 16);
    d = 8'((n + 13) % 16);
    return {a, b, c, d};
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance a signals
  logic        a_v0 = 0, a_v1 = 0, a_l0 = 0, a_l1 = 0;
  logic [31:0] a_d0 = 0, a_d1 = 0;
  logic        a_r0, a_r1, a_rv0, a_rv1, a_busy;
  logic [31:0] a_rd0, a_rd1, a_x, a_y;
  // instance b signals
  logic        b_v0 = 0, b_v1 = 0;
  logic [31:0] b_d0 = 0, b_d1 = 0;
  logic        b_r0, b_r1, b_rv0, b_rv1, b_busy;
  logic [31:0] b_rd0, b_rd1, b_x, b_y, b_p1, b_p2;

  sm4_sbox_arb #(.SBOX_LAT(1), .DW(32)) u_a (
    .CLK_i(clk), .RSTn_i(rst_n), .EN_i(en),
    .req0_valid_i(a_v0), .req0_data_i(a_d0), .req0_lock_i(a_l0), .req0_ready_o(a_r0),
    .rsp0_valid_o(a_rv0), .rsp0_data_o(a_rd0),
    .req1_valid_i(a_v1), .req1_data_i(a_d1), .req1_lock_i(a_l1), .req1_ready_o(a_r1),
    .rsp1_valid_o(a_rv1), .rsp1_data_o(a_rd1),
    .sbox_x_o(a_x), .sbox_y_i(a_y), .busy_o(a_busy));

  sm4_sbox_arb #(.SBOX_LAT(3), .DW(32)) u_b (
    .CLK_i(clk), .RSTn_i(rst_n), .EN_i(1'b1),
    .req0_valid_i(b_v0), .req0_data_i(b_d0), .req0_lock_i(1'b0), .req0_ready_o(b_r0),
    .rsp0_valid_o(b_rv0), .rsp0_data_o(b_rd0),
    .req1_valid_i(b_v1), .req1_data_i(b_d1), .req1_lock_i(1'b0), .req1_ready_o(b_r1),
    .rsp1_valid_o(b_rv1), .rsp1_data_o(b_rd1),
    .sbox_x_o(b_x), .sbox_y_i(b_y), .busy_o(b_busy));

  // S-box stand-ins: 1 and 3 register stages
  always @(posedge clk) begin
    a_y  <= sub32(a_x);
    b_p1 <= sub32(b_x);
    b_p2 <= b_p1;
    b_y  <= b_p2;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Response scoreboard: each accepted word must return to its requester
  // exactly LAT+2 cycles after the cycle it was accepted in, in order.
  typedef struct {
    int          c;
    logic        id;
    logic [31:0] d;
  } ent_t;
  ent_t qa[$];
  ent_t qb[$];
  logic mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (a_r0 && a_v0) qa.push_back('{c: cyc, id: 1'b0, d: a_d0});
      if (a_r1 && a_v1) qa.push_back('{c: cyc, id: 1'b1, d: a_d1});
      if (qa.size() > 0 && qa[0].c + 3 == cyc) begin
        chk("a_rsp0_v", 32'(a_rv0), 32'(!qa[0].id));
        chk("a_rsp1_v", 32'(a_rv1), 32'(qa[0].id));
        chk("a_rsp_d", qa[0].id ? a_rd1 : a_rd0, sub32(qa[0].d));
        qa.delete(0);
      end else begin
        chk("a_rsp0_idle", 32'(a_rv0), 32'(0));
        chk("a_rsp1_idle", 32'(a_rv1), 32'(0));
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (b_r0 && b_v0) qb.push_back('{c: cyc, id: 1'b0, d: b_d0});
      if (b_r1 && b_v1) qb.push_back('{c: cyc, id: 1'b1, d: b_d1});
      if (qb.size() > 0 && qb[0].c + 5 == cyc) begin
        chk("b_rsp0_v", 32'(b_rv0), 32'(!qb[0].id));
        chk("b_rsp1_v", 32'(b_rv1), 32'(qb[0].id));
        chk("b_rsp_d", qb[0].id ? b_rd1 : b_rd0, sub32(qb[0].d));
        qb.delete(0);
      end else begin
        chk("b_rsp0_idle", 32'(b_rv0), 32'(0));
        chk("b_rsp1_idle", 32'(b_rv1), 32'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int k0 = 0;
  int k1 = 0;

  // One instance-a cycle: check readies (and optionally busy), then advance
  // the data of whichever requester should have been accepted.
  task automatic cyc2(input logic e0, input logic e1, input int eb, input string tag);
    @(negedge clk);
    chk({tag, "_rdy0"}, 32'(a_r0), 32'(e0));
    chk({tag, "_rdy1"}, 32'(a_r1), 32'(e1));
    if (eb >= 0) chk({tag, "_busy"}, 32'(a_busy), 32'(eb));
    tick();
    if (e0) begin k0++; a_d0 = mk(2 * k0); end
    if (e1) begin k1++; a_d1 = mk(2 * k1 + 1); end
  endtask

  initial begin
    // reset with both requesters valid: readies must stay low
    a_v0 = 1; a_v1 = 1; rst_n = 0;
    tick(); tick();
    @(negedge clk);
    chk("rst_rdy0", 32'(a_r0), 32'(0));
    chk("rst_rdy1", 32'(a_r1), 32'(0));
    chk("rst_rsp0_v", 32'(a_rv0), 32'(0));
    chk("rst_rsp1_v", 32'(a_rv1), 32'(0));
    chk("rst_rsp0_d", a_rd0, 32'h0);
    chk("rst_rsp1_d", a_rd1, 32'h0);
    chk("rst_sbox_x", a_x, 32'h0);
    chk("rst_busy", 32'(a_busy), 32'(0));
    tick();
    a_v0 = 0; a_v1 = 0; rst_n = 1; mon_en = 1;
    tick();

    // single lookup from requester 0
    a_d0 = 32'h00010203; a_v0 = 1;
    @(negedge clk);
    chk("t1_rdy0", 32'(a_r0), 32'(1));
    chk("t1_rdy1", 32'(a_r1), 32'(0));
    tick(); a_v0 = 0;
    @(negedge clk);
    chk("t1_sbox_x", a_x, 32'h00010203);
    chk("t1_busy", 32'(a_busy), 32'(1));
    tick();
    @(negedge clk);
    chk("t1_rsp0_early", 32'(a_rv0), 32'(0));
    tick();
    @(negedge clk);
    chk("t1_rsp0_v", 32'(a_rv0), 32'(1));
    chk("t1_rsp0_d", a_rd0, 32'hD690E9FE);
    chk("t1_rsp1_v", 32'(a_rv1), 32'(0));
    tick();
    @(negedge clk);
    chk("t1_rsp0_pulse", 32'(a_rv0), 32'(0));
    tick();

    // reset back to last_grant=1, then round-robin contention
    rst_n = 0; tick(); qa.delete(); rst_n = 1;
    k0 = 0; k1 = 0; a_d0 = mk(0); a_d1 = mk(1);
    a_v0 = 1; a_v1 = 1;
    for (int i = 0; i < 8; i++) cyc2(i % 2 == 0, i % 2 == 1, -1, "rr");

    // burst lock held by requester 1 (last_grant=1)
    a_l1 = 1;
    for (int i = 0; i < 4; i++) cyc2(0, 1, -1, "lock1");
    a_l1 = 0;
    cyc2(1, 0, -1, "unlock1");
    a_l0 = 1;
    cyc2(1, 0, -1, "lock0");
    cyc2(1, 0, -1, "lock0");
    a_l0 = 0;
    cyc2(0, 1, -1, "unlock0");

    // enable gating: last grant went to 1, in-flight lookups drain
    en = 0;
    cyc2(0, 0, -1, "en0");
    cyc2(0, 0, -1, "en0");
    cyc2(0, 0, 1, "en0");
    cyc2(0, 0, 0, "en0");
    en = 1;
    cyc2(1, 0, -1, "en1");
    cyc2(0, 1, -1, "en1");

    // mid-operation reset with two lookups in flight
    cyc2(1, 0, -1, "pre_rst");
    cyc2(0, 1, -1, "pre_rst");
    rst_n = 0;
    cyc2(0, 0, -1, "in_rst");
    qa.delete(); rst_n = 1;
    @(negedge clk);
    chk("post_rst_busy", 32'(a_busy), 32'(0));
    chk("post_rst_sbox_x", a_x, 32'h0);
    chk("post_rst_rdy0", 32'(a_r0), 32'(1));
    chk("post_rst_rdy1", 32'(a_r1), 32'(0));
    tick();
    k0++; a_d0 = mk(2 * k0);
    cyc2(0, 1, -1, "post_rst");
    a_v0 = 0; a_v1 = 0;
    for (int i = 0; i < 6; i++) cyc2(0, 0, -1, "drain");

    // SBOX_LAT=3: 16 back-to-back words
    b_v0 = 1;
    for (int i = 0; i < 16; i++) begin
      b_d0 = mk(i + 3);
      @(negedge clk);
      chk("b_rdy0", 32'(b_r0), 32'(1));
      chk("b_rdy1", 32'(b_r1), 32'(0));
      tick();
    end
    b_v0 = 0;
    for (int i = 0; i < 8; i++) tick();
    @(negedge clk);
    chk("b_busy_end", 32'(b_busy), 32'(0));
    chk("qa_empty", 32'(qa.size()), 32'(0));
    chk("qb_empty", 32'(qb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
